// File: rtl/door_sequencer.sv
// Door motor sequencer: STOP/OPENING/OPEN/CLOSING/FAULT FSM with a shared cycle counter.
// Optional hold-time auto-close in OPEN is enabled by defining DOOR_AUTO_CLOSE_EN.
module door_sequencer #(
   parameter int unsigned HOLD_CYCLES = 20,
   parameter int unsigned TRAVEL_MAX  = 40
) (
   input  logic clk2m,
   input  logic rst_n,
   input  logic key_up,
   input  logic key_down,
   input  logic sense_up,
   input  logic sense_down,
   input  logic obstruction,
   output logic ml,
   output logic mr,
   output logic light_red,
   output logic light_green,
   output logic fault
);

   localparam int unsigned CNT_MAX_VAL = (HOLD_CYCLES > TRAVEL_MAX) ? HOLD_CYCLES : TRAVEL_MAX;
   localparam int unsigned CW          = $clog2(CNT_MAX_VAL + 1);
   localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_MAX - 1);
`ifdef DOOR_AUTO_CLOSE_EN
   localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
`endif

   typedef enum logic [2:0] {
      ST_STOP,
      ST_OPENING,
      ST_OPEN,
      ST_CLOSING,
      ST_FAULT
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic          hold_restart;

   always_ff @(posedge clk2m) begin
      if (!rst_n) state <= ST_STOP;
      else        state <= state_nxt;
   end

   // Contradictory end-stops override everything, including the FAULT hold.
   always_comb begin
      state_nxt    = state;
      hold_restart = 1'b0;
      if (sense_up && sense_down) begin
         state_nxt = ST_FAULT;
      end else begin
         case (state)
            ST_STOP: begin
               if (sense_up)                     state_nxt = ST_OPEN;
               else if (key_up)                  state_nxt = ST_OPENING;
               else if (key_down && !sense_down) state_nxt = ST_CLOSING;
            end
            ST_OPENING: begin
               if (sense_up)                 state_nxt = ST_OPEN;
               else if (cnt == TRAVEL_LAST)  state_nxt = ST_FAULT;
            end
            ST_OPEN: begin
               if (key_up)        hold_restart = 1'b1;
               else if (key_down) state_nxt = ST_CLOSING;
`ifdef DOOR_AUTO_CLOSE_EN
               else if (cnt == HOLD_LAST) state_nxt = ST_CLOSING;
`endif
            end
            ST_CLOSING: begin
               if (sense_down)                 state_nxt = ST_STOP;
               else if (obstruction || key_up) state_nxt = ST_OPENING;
               else if (cnt == TRAVEL_LAST)    state_nxt = ST_FAULT;
            end
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_FAULT;
         endcase
      end
   end

   always_ff @(posedge clk2m) begin
      if (!rst_n)                               cnt <= '0;
      else if (state_nxt != state || hold_restart) cnt <= '0;
      else if (cnt != '1)                       cnt <= cnt + CW'(1);
   end

   always_comb begin
      ml          = 1'b0;
      mr          = 1'b0;
      light_red   = 1'b1;
      light_green = 1'b0;
      fault       = 1'b0;
      case (state)
         ST_OPENING: ml = 1'b1;
         ST_CLOSING: mr = 1'b1;
         ST_OPEN: begin
            light_red   = 1'b0;
            light_green = 1'b1;
         end
         ST_FAULT:   fault = 1'b1;
         default:    ;
      endcase
   end

endmodule

// File: tb/tb_door_sequencer.sv
// Directed, table-driven bench for door_sequencer plus hand-written multi-cycle sequences.
// Outputs are compared as {ml, mr, light_red, light_green, fault}.
`timescale 1ns/1ps
module tb_door_sequencer;

   localparam logic [4:0] O_STOP    = 5'b00100;
   localparam logic [4:0] O_OPENING = 5'b10100;
   localparam logic [4:0] O_OPEN    = 5'b00010;
   localparam logic [4:0] O_CLOSING = 5'b01100;
   localparam logic [4:0] O_FAULT   = 5'b00101;

   logic clk2m = 1'b0;
   logic rst_n, key_up, key_down, sense_up, sense_down, obstruction;
   logic ml, mr, light_red, light_green, fault;

   int n_cmp = 0;
   int n_err = 0;

   door_sequencer #(.HOLD_CYCLES(20), .TRAVEL_MAX(40)) dut (
      .clk2m(clk2m), .rst_n(rst_n), .key_up(key_up), .key_down(key_down),
      .sense_up(sense_up), .sense_down(sense_down), .obstruction(obstruction),
      .ml(ml), .mr(mr), .light_red(light_red), .light_green(light_green), .fault(fault)
   );

   always #250 clk2m = ~clk2m;

   typedef struct {
      string      name;
      logic [5:0] in;   // {rst_n, key_up, key_down, sense_up, sense_down, obstruction}
      logic [4:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic drive(input logic [5:0] in);
      {rst_n, key_up, key_down, sense_up, sense_down, obstruction} = in;
   endtask

   // Apply inputs, take one rising edge, sample 1 ns later.
   task automatic step(input logic [5:0] in);
      drive(in);
      @(posedge clk2m);
      #1;
   endtask

   task automatic chk(input string name, input logic [4:0] exp);
      logic [4:0] act;
      act = {ml, mr, light_red, light_green, fault};
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got {ml,mr,red,green,fault}=%b, expected %b", name, act, exp);
      end
   endtask

   initial begin
      drive(6'b000010);
      @(posedge clk2m);
      #1;

      //                         r ku kd su sd ob
      vecs.push_back('{"rst_stop",      6'b000010, O_STOP});
      vecs.push_back('{"idle_stop",     6'b100010, O_STOP});
      vecs.push_back('{"kup_opening",   6'b110010, O_OPENING});
      vecs.push_back('{"opening_hold",  6'b100000, O_OPENING});
      vecs.push_back('{"su_open",       6'b100100, O_OPEN});
      vecs.push_back('{"open_idle",     6'b100100, O_OPEN});
      vecs.push_back('{"open_bothkeys", 6'b111100, O_OPEN});
      vecs.push_back('{"kdn_closing",   6'b101100, O_CLOSING});
      vecs.push_back('{"obst_reverse",  6'b100001, O_OPENING});
      vecs.push_back('{"su_open2",      6'b100100, O_OPEN});
      vecs.push_back('{"kdn_closing2",  6'b101000, O_CLOSING});
      vecs.push_back('{"sd_stop",       6'b100010, O_STOP});
      vecs.push_back('{"kdn_at_bottom", 6'b101010, O_STOP});
      vecs.push_back('{"kdn_closing3",  6'b101000, O_CLOSING});
      vecs.push_back('{"kup_reverse",   6'b110000, O_OPENING});
      vecs.push_back('{"both_sense",    6'b100110, O_FAULT});
      vecs.push_back('{"fault_kup",     6'b110000, O_FAULT});
      vecs.push_back('{"fault_su",      6'b100100, O_FAULT});
      vecs.push_back('{"rst_from_fault",6'b000000, O_STOP});
      vecs.push_back('{"su_kup_open",   6'b110100, O_OPEN});
      vecs.push_back('{"rst_from_open", 6'b011100, O_STOP});
      vecs.push_back('{"stop_both_sns", 6'b100110, O_FAULT});

      foreach (vecs[i]) begin
         step(vecs[i].in);
         chk(vecs[i].name, vecs[i].exp);
      end

      // Reset then 50 idle cycles at the bottom end-stop.
      step(6'b000010);
      chk("seqA_reset", O_STOP);
      for (int i = 0; i < 50; i++) begin
         step(6'b100010);
         chk("seqA_stop50", O_STOP);
      end

      // Open travel of 10 cycles, then hold behaviour in OPEN.
      step(6'b110010);
      chk("seqB_kup", O_OPENING);
      for (int i = 0; i < 9; i++) begin
         step(6'b100000);
         chk("seqB_travel", O_OPENING);
      end
      step(6'b100100);
      chk("seqB_open", O_OPEN);
`ifdef DOOR_AUTO_CLOSE_EN
      for (int k = 1; k <= 20; k++) begin
         step(6'b100100);
         chk("seqB_autoclose", (k == 20) ? O_CLOSING : O_OPEN);
      end
      // Key restart in OPEN delays auto-close to 20 cycles after the key cycle.
      step(6'b000000);
      step(6'b100100);
      chk("seqE_open", O_OPEN);
      for (int k = 0; k < 5; k++) step(6'b100100);
      step(6'b111100);
      chk("seqE_restart", O_OPEN);
      for (int k = 1; k <= 20; k++) begin
         step(6'b100100);
         chk("seqE_delayed", (k == 20) ? O_CLOSING : O_OPEN);
      end
`else
      for (int k = 1; k <= 100; k++) begin
         step(6'b100100);
         chk("seqB_nohold", O_OPEN);
      end
`endif

      // Long close, reversal restarts the 40-cycle budget, then timeout.
      step(6'b000000);
      step(6'b101000);
      chk("seqC_closing", O_CLOSING);
      for (int i = 0; i < 30; i++) step(6'b100000);
      chk("seqC_still_closing", O_CLOSING);
      step(6'b100001);
      chk("seqC_reverse", O_OPENING);
      for (int k = 1; k <= 40; k++) begin
         step(6'b100000);
         chk("seqC_timeout", (k == 40) ? O_FAULT : O_OPENING);
      end
      step(6'b110000);
      chk("seqC_fault_kup", O_FAULT);
      step(6'b010000);
      chk("seqC_fault_rst", O_STOP);
      step(6'b100000);
      chk("seqC_after_rst", O_STOP);

      // Closing timeout without any reversal.
      step(6'b101000);
      chk("seqF_closing", O_CLOSING);
      for (int k = 1; k <= 40; k++) begin
         step(6'b100000);
         chk("seqF_timeout", (k == 40) ? O_FAULT : O_CLOSING);
      end

      // Reset mid-CLOSING, held low with key_down asserted, then released.
      step(6'b000000);
      step(6'b101000);
      chk("seqD_closing", O_CLOSING);
      step(6'b001000);
      chk("seqD_rst_edge", O_STOP);
      for (int i = 0; i < 3; i++) begin
         step(6'b001000);
         chk("seqD_rst_hold", O_STOP);
      end
      step(6'b101000);
      chk("seqD_first_edge", O_CLOSING);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/door_sequencer.md
DOOR_SEQUENCER -- requirements
Module: door_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 20, clk2m cycles the door stays open before auto-close (10 us at 2 MHz).
REQ-002 Parameter TRAVEL_MAX, default 40, maximum clk2m cycles allowed in one motion state before fault.
REQ-003 clk2m  input  1  system clock, 2 MHz; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 key_up  input  1  open request, level, synchronous to clk2m.
REQ-006 key_down  input  1  close request, level, synchronous to clk2m.
REQ-007 sense_up  input  1  door fully open end-stop.
REQ-008 sense_down  input  1  door fully closed end-stop.
REQ-009 obstruction  input  1  light-barrier blocked while closing.
REQ-010 ml  output  1  motor drive, open direction.
REQ-011 mr  output  1  motor drive, close direction.
REQ-012 light_red  output  1  door not passable.
REQ-013 light_green  output  1  door open and passable.
REQ-014 fault  output  1  latched fault indicator.

Function
REQ-015 The FSM SHALL have states STOP, OPENING, OPEN, CLOSING and FAULT in a single state register.
REQ-016 Outputs SHALL decode from the registered state only; no combinational input-to-output path; response latency is one clk2m cycle.
REQ-017 Output decoding SHALL be: OPENING ml=1; CLOSING mr=1; OPEN light_green=1, light_red=0; FAULT fault=1; all other outputs 0, except light_red=1 in every state but OPEN.
REQ-018 ml and mr SHALL never be 1 simultaneously.
REQ-019 STOP: sense_up -> OPEN; else key_up -> OPENING; else key_down and not sense_down -> CLOSING; else stay.
REQ-020 OPENING: sense_up -> OPEN; else timeout -> FAULT.
REQ-021 OPEN: key_up (alone or together with key_down) SHALL restart the hold counter and stay OPEN; key_down alone -> CLOSING.
REQ-022 CLOSING: sense_down -> STOP; else obstruction or key_up -> OPENING (reversal); else timeout -> FAULT.
REQ-023 sense_up and sense_down both 1 in any state SHALL force FAULT on the next edge (highest priority after reset).
REQ-024 FAULT SHALL be left only through reset; all key, sense and obstruction inputs are ignored.
REQ-025 One shared cycle counter, width $clog2(max(HOLD_CYCLES,TRAVEL_MAX)+1), SHALL clear on every state change and on key_up restart in OPEN, increment otherwise, saturate at its maximum.
REQ-026 Timeout: in OPENING/CLOSING, counter == TRAVEL_MAX-1 with no exit condition SHALL give FAULT next edge (at most TRAVEL_MAX cycles of motion).
REQ-027 A reversal CLOSING -> OPENING SHALL restart the travel budget at 0.

Reset
REQ-028 rst_n=0 sampled at a clk2m rising edge SHALL force STOP, counter 0, ml=0, mr=0, light_red=1, light_green=0, fault=0, regardless of state, including FAULT and mid-motion.
REQ-029 While rst_n=0 outputs SHALL hold the reset values; the first transition SHALL occur on the first edge with rst_n=1.

Configuration
REQ-030 Macro DOOR_AUTO_CLOSE_EN defined: in OPEN, counter == HOLD_CYCLES-1 with no key input SHALL give CLOSING next edge.
REQ-031 Macro DOOR_AUTO_CLOSE_EN undefined: OPEN SHALL persist indefinitely until key_down; hold-timeout logic is absent.

Verification
REQ-032 Reset with sense_down=1, keys 0 -> ml=0, mr=0, light_red=1, light_green=0, fault=0; stays STOP for 50 cycles.
REQ-033 key_up 1 cycle in STOP -> ml=1 next cycle; sense_up=1 after 10 cycles -> ml=0, light_green=1 next cycle; with DOOR_AUTO_CLOSE_EN mr=1 exactly 20 cycles after OPEN entry, without it mr stays 0 for 100 cycles.
REQ-034 In OPEN, key_up=key_down=1 for 1 cycle -> stays OPEN, light_green=1, auto-close delayed to 20 cycles after the key cycle.
REQ-035 In CLOSING, obstruction=1 for 1 cycle -> mr=0, ml=1 next cycle; then 40 cycles without sense_up -> fault=1, ml=0.
REQ-036 FAULT, then key_up=1 -> no change; rst_n=0 for one edge -> reset values on that edge, STOP afterwards.
REQ-037 sense_up=sense_down=1 in STOP -> fault=1 next cycle; rst_n=0 mid-CLOSING -> mr=0 on the same reset edge.
